serial_encoder: RTL

Parallel-in/serial-out frame encoder, the transmit end of the team's 8-bit serial link. Accepts a byte over a valid/ready handshake. Shifts it out LSB first, one bit per clock, then drives a one-cycle gap slot flagged by `frameSync`, which lines up with the receiving SIPO's load cycle. A one-entry holding buffer allows back-to-back frames with no idle cycles between them.

---
 rtl/serial_link_pkg.sv | 15 +
 rtl/frame_counter.sv | 27 ++
 rtl/serial_encoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the 8-bit serial link (transmit and receive sides).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_link_pkg;

  localparam int LINK_WIDTH = 8;
  localparam int LINK_GAP   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } enc_state_t;

endpackage

// File: rtl/frame_counter.sv
// Clearable up-counter flagging the last count of a bit or gap phase.
// Latency: clear/enable take effect on the next edge; terminal is combinational from the count.
// Backpressure: none; holds its value while enable is low.
module frame_counter #(
  parameter int CNT_W = 4,
  parameter int LAST  = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(LAST));

endmodule

// File: rtl/serial_encoder.sv
// PISO frame encoder: byte in over valid/ready, LSB-first bits out, then frameSync gap slots.
// Latency: bit 0 appears the cycle after accept; frames repeat every WIDTH+GAP_CYCLES cycles.
// Backpressure: one-entry holding buffer; inReady drops while it is full.
module serial_encoder
  import serial_link_pkg::*;
#(
  parameter int WIDTH      = LINK_WIDTH,
  parameter int GAP_CYCLES = LINK_GAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             inValid,
  output logic             inReady,
  output logic             serialOut,
  output logic             frameSync,
  output logic             busy
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  enc_state_t       state;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] bufData;
  logic             bufValid;
  logic             accept;
  logic             bit_clr, bit_en, bit_last;
  logic             gap_clr, gap_en, gap_last;

  assign inReady = !bufValid && !reset;
  assign accept  = inValid && inReady;
  assign busy    = (state != IDLE);

  always_comb begin
    bit_clr = 1'b0;
    bit_en  = 1'b0;
    gap_clr = 1'b0;
    gap_en  = 1'b0;
    case (state)
      IDLE:  bit_clr = accept;
      SHIFT: begin
        bit_en  = !bit_last;
        gap_clr = bit_last;
      end
      GAP: begin
        gap_en  = !gap_last;
        bit_clr = gap_last;
      end
      default: ;
    endcase
  end

  frame_counter #(.CNT_W(BIT_W), .LAST(WIDTH - 1)) u_bit_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (bit_clr),
    .enable   (bit_en),
    .terminal (bit_last)
  );

  frame_counter #(.CNT_W(GAP_W), .LAST(GAP_CYCLES - 1)) u_gap_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (gap_clr),
    .enable   (gap_en),
    .terminal (gap_last)
  );

  // serialOut is registered one step ahead: shiftReg[0] is always the bit on the line.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bufData   <= '0;
      bufValid  <= 1'b0;
      serialOut <= 1'b0;
      frameSync <= 1'b0;
    end else begin
      if (accept && (state != IDLE) && !((state == GAP) && gap_last)) begin
        bufData  <= parallelIn;
        bufValid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            shiftReg  <= parallelIn;
            serialOut <= parallelIn[0];
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_last) begin
            serialOut <= 1'b0;
            frameSync <= 1'b1;
            state     <= GAP;
          end else begin
            shiftReg  <= shiftReg >> 1;
            serialOut <= shiftReg[1];
          end
        end
        GAP: begin
          if (gap_last) begin
            frameSync <= 1'b0;
            if (bufValid) begin
              shiftReg  <= bufData;
              serialOut <= bufData[0];
              bufValid  <= 1'b0;
              state     <= SHIFT;
            end else if (accept) begin
              shiftReg  <= parallelIn;
              serialOut <= parallelIn[0];
              state     <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
